// File: rtl/aes256_cop_master.sv
`default_nettype none
// ============================================================================
// Module   : aes256_cop_master
// Purpose  : Bus-side initiator for the AES-256 co-processor register port.
//            On start it resets the co-processor, loads key and nonce, sets
//            run, then moves plaintext words from a valid/ready input stream
//            into the co-processor and result words back out to a valid/ready
//            output stream until num_blocks 128-bit blocks have returned.
// Ports    : clock_i/reset_i        - clock, synchronous active-high reset
//            start_i, key_i,
//            nonce_i, num_blocks_i  - job request and its parameters
//            busy_o/done_o/error_o  - job status
//            in_*                   - plaintext stream (in_ready_o is comb.)
//            out_*                  - result stream (registered)
//            cop_*                  - co-processor register port
// Revision : 1.0 - initial release
// ============================================================================
module aes256_cop_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [255:0] key_i,
    input  logic [127:0] nonce_i,
    input  logic [15:0]  num_blocks_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    input  logic [31:0]  in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [31:0]  out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [3:0]   cop_addr_o,
    output logic [31:0]  cop_data_in_o,
    output logic         cop_write_en_o,
    input  logic [31:0]  cop_data_out_i
);

    localparam int             WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] C_TIMEOUT = WDW'(TIMEOUT);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RST   = 4'd1,
        ST_REL   = 4'd2,
        ST_KEY   = 4'd3,
        ST_NONCE = 4'd4,
        ST_RUN   = 4'd5,
        ST_STAT  = 4'd6,
        ST_PUSH  = 4'd7,
        ST_PEEK  = 4'd8,
        ST_POP   = 4'd9,
        ST_STOP  = 4'd10
    } state_e;

    state_e         state_q;
    logic [255:0]   key_q;
    logic [127:0]   nonce_q;
    logic [15:0]    nblk_q;
    logic [2:0]     idx_q;
    logic [17:0]    in_cnt_q;
    logic [17:0]    out_cnt_q;
    logic [WDW-1:0] wdog_q;
    logic           busy_q;
    logic           done_q;
    logic           error_q;
    logic           out_valid_q;
    logic [31:0]    out_data_q;
    logic [3:0]     cop_addr_q;
    logic [31:0]    cop_wdata_q;
    logic           cop_we_q;

    logic [17:0]    w_total;
    logic           w_out_done;
    logic           w_in_more;
    logic           w_want_peek;
    logic           w_push_ok;
    logic [2:0]     w_idx_nxt;
    logic [WDW-1:0] w_wdog_inc;

    // Counters are 18 bits so 4 * 0xFFFF words fit without wrapping.
    assign w_total     = {nblk_q, 2'b00};
    assign w_out_done  = (out_cnt_q == w_total);
    assign w_in_more   = (in_cnt_q < w_total);
    // Status word: bit 30 = iw_full, bit 27 = ow_empty.
    assign w_want_peek = !cop_data_out_i[27] && !out_valid_q;
    // Output drain has priority over input push.
    assign w_push_ok   = (state_q == ST_STAT) && !w_out_done && !w_want_peek &&
                         w_in_more && !cop_data_out_i[30] && in_valid_i;
    assign w_idx_nxt   = idx_q + 3'd1;
    assign w_wdog_inc  = wdog_q + 1'b1;

    assign in_ready_o     = w_push_ok;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign out_data_o     = out_data_q;
    assign out_valid_o    = out_valid_q;
    assign cop_addr_o     = cop_addr_q;
    assign cop_data_in_o  = cop_wdata_q;
    assign cop_write_en_o = cop_we_q;

    // Bus outputs are loaded on entry to each state, so they always describe
    // the cycle the FSM is currently in.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            nonce_q     <= '0;
            nblk_q      <= '0;
            idx_q       <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            wdog_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cop_addr_q  <= '0;
            cop_wdata_q <= '0;
            cop_we_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        key_q     <= key_i;
                        nonce_q   <= nonce_i;
                        nblk_q    <= num_blocks_i;
                        error_q   <= 1'b0;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        wdog_q    <= '0;
                        if (num_blocks_i == 16'd0) begin
                            // Empty job: finish without touching the bus.
                            done_q <= 1'b1;
                        end else begin
                            busy_q      <= 1'b1;
                            state_q     <= ST_RST;
                            cop_addr_q  <= 4'd0;
                            cop_wdata_q <= 32'd2;
                            cop_we_q    <= 1'b1;
                        end
                    end
                end
                ST_RST: begin
                    state_q     <= ST_REL;
                    cop_wdata_q <= 32'd0;
                end
                ST_REL: begin
                    state_q     <= ST_KEY;
                    idx_q       <= 3'd0;
                    cop_addr_q  <= 4'd5;
                    cop_wdata_q <= key_q[31:0];
                end
                ST_KEY: begin
                    if (idx_q == 3'd7) begin
                        state_q     <= ST_NONCE;
                        idx_q       <= 3'd0;
                        cop_addr_q  <= 4'd1;
                        cop_wdata_q <= nonce_q[31:0];
                    end else begin
                        idx_q       <= w_idx_nxt;
                        cop_addr_q  <= 4'd5 + {1'b0, w_idx_nxt};
                        cop_wdata_q <= key_q[{w_idx_nxt, 5'b00000} +: 32];
                    end
                end
                ST_NONCE: begin
                    if (idx_q == 3'd3) begin
                        state_q     <= ST_RUN;
                        idx_q       <= 3'd0;
                        cop_addr_q  <= 4'd0;
                        cop_wdata_q <= 32'd1;
                    end else begin
                        idx_q       <= w_idx_nxt;
                        cop_addr_q  <= 4'd1 + {2'b00, w_idx_nxt[1:0]};
                        cop_wdata_q <= nonce_q[{w_idx_nxt[1:0], 5'b00000} +: 32];
                    end
                end
                ST_RUN, ST_PUSH, ST_POP: begin
                    // Always re-read status before the next decision.
                    state_q     <= ST_STAT;
                    cop_addr_q  <= 4'd0;
                    cop_wdata_q <= 32'd0;
                    cop_we_q    <= 1'b0;
                end
                ST_STAT: begin
                    if (w_out_done) begin
                        state_q     <= ST_STOP;
                        cop_addr_q  <= 4'd0;
                        cop_wdata_q <= 32'd0;
                        cop_we_q    <= 1'b1;
                    end else if (w_want_peek) begin
                        state_q    <= ST_PEEK;
                        cop_addr_q <= 4'd14;
                    end else if (w_push_ok) begin
                        state_q     <= ST_PUSH;
                        cop_addr_q  <= 4'd13;
                        cop_wdata_q <= in_data_i;
                        cop_we_q    <= 1'b1;
                        in_cnt_q    <= in_cnt_q + 18'd1;
                        wdog_q      <= '0;
                    end else if (w_wdog_inc == C_TIMEOUT) begin
                        error_q     <= 1'b1;
                        state_q     <= ST_STOP;
                        cop_addr_q  <= 4'd0;
                        cop_wdata_q <= 32'd0;
                        cop_we_q    <= 1'b1;
                    end else begin
                        wdog_q <= w_wdog_inc;
                    end
                end
                ST_PEEK: begin
                    out_data_q  <= cop_data_out_i;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_POP;
                    cop_wdata_q <= 32'd0;
                    cop_we_q    <= 1'b1;
                    out_cnt_q   <= out_cnt_q + 18'd1;
                    wdog_q      <= '0;
                end
                ST_STOP: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    cop_we_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    cop_we_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/aes256_cop_master.md
# aes256_cop_master

Bus-side initiator that drives the AES-256 co-processor register port on behalf of a streaming client. On `start` it resets the co-processor, programs key and nonce, sets `run`, then pushes plaintext words from a valid/ready input stream and pops keystream-XORed words into a valid/ready output stream until `num_blocks` 128-bit blocks have been returned. It sits between a DMA/stream fabric and the co-processor socket, replacing CPU-driven polling.

## Interface
- `TIMEOUT`, 1024: idle cycles in STAT with no push/pop before abort.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle job request; ignored while `busy`.
- `key`  in  256  sampled on accepted `start`; word i = `key[32i+31:32i]`.
- `nonce`  in  128  sampled on accepted `start`; word i = `nonce[32i+31:32i]`.
- `num_blocks`  in  16  sampled on accepted `start`; job length in 128-bit blocks.
- `busy`  out  1  high from cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at job end (normal or abort).
- `error`  out  1  set on watchdog abort; cleared by next accepted `start` or `reset`.
- `in_data`  in  32  plaintext word.
- `in_valid`  in  1  `in_data` valid; held until accepted.
- `in_ready`  out  1  combinational; handshake when `in_valid & in_ready`.
- `out_data`  out  32  result word (registered).
- `out_valid`  out  1  held until `out_ready`.
- `out_ready`  in  1  consumer accepts.
- `cop_addr`  out  4  co-processor register address (registered).
- `cop_data_in`  out  32  write data to co-processor (registered).
- `cop_write_en`  out  1  write strobe (registered).
- `cop_data_out`  in  32  co-processor read data, combinational on `cop_addr`.

## Operation
- Register map driven: 0 control/status (write bits[1:0] = {reset, run}; read bits[31:24] = {iw_empty, iw_full, ib_empty, ib_full, ow_empty, ow_full, ob_empty, ob_full}); 1-4 nonce words 0-3; 5-12 key words 0-7; 13 push input word (write); 14 output word (read), pop strobe (write, data 0).
- Read cycle: `cop_write_en`=0, `cop_addr`=A; `cop_data_out` sampled on the edge ending that cycle.
- FSM: IDLE -> RST (write 0 <= 2'b10) -> REL (write 0 <= 2'b00) -> KEY (8 writes, addr 5..12, words 0..7) -> NONCE (4 writes, addr 1..4) -> RUN (write 0 <= 2'b01) -> STAT.
- STAT (read addr 0), decision at end of cycle, priority order:
  1. `out_cnt` == 4*`num_blocks` -> STOP.
  2. `ow_empty`=0 and `out_valid`=0 -> PEEK.
  3. `in_cnt` < 4*`num_blocks`, `iw_full`=0, `in_valid`=1 -> `in_ready`=1 this cycle; capture `in_data`; -> PUSH.
  4. Otherwise stay in STAT; watchdog increments.
- PUSH: write addr 13 <= captured word; `in_cnt`++; -> STAT.
- PEEK: read addr 14; `out_data` <= `cop_data_out`, `out_valid` <= 1 at end of cycle; -> POP.
- POP: write addr 14 <= 0; `out_cnt`++; -> STAT.
- STOP: write 0 <= 2'b00; `done`=1 next cycle; -> IDLE.
- Counters 18 bits; compare against `{num_blocks, 2'b00}`; `num_blocks`=0xFFFF must not overflow.
- `num_blocks`=0: `start` -> `done` pulse next cycle, zero co-processor writes.
- Watchdog: cleared on PUSH/POP entry and on start; reaching `TIMEOUT` in STAT -> set `error`, -> STOP.
- `out_valid` clears on `out_ready`; `out_data` stable while `out_valid` is high and `out_ready` is low.

## Timing
- Reset values: `busy`, `done`, `error`, `in_ready`, `out_valid`, `cop_write_en` = 0; `cop_addr`, `cop_data_in`, `out_data` = 0; FSM IDLE; counters 0.
- `reset` mid-job: all of the above in the next cycle; no further co-processor writes.
- Setup: 15 consecutive write cycles (RST..RUN); first STAT is cycle 16 after `start`.
- Input word: 2 cycles (STAT+PUSH). Output word: 3 cycles (STAT+PEEK+POP). After PUSH/POP, status is always re-read before the next decision; flags are never reused.
- `busy` falls in the same cycle `done` pulses.
- `in_ready` is never asserted outside STAT, or while `out_valid` is 0 and `ow_empty` is 0, because output has priority.

## Test plan
- Reset, then `start` with `num_blocks`=1 and incrementing key/nonce -> first 15 writes are (0,2), (0,0), (5..12, key words 0..7), (1..4, nonce words 0..3), (0,1) in that exact order.
- 1 block, model returns words 0xA0..0xA3 -> 4 PUSH writes to addr 13, 4 PEEK/POP pairs, `out_data` = 0xA0..0xA3 in order, then write (0,0), `done` pulse, `error`=0.
- Hold `out_ready`=0 for 50 cycles while `ow_empty`=0 -> `out_valid`=1 with `out_data` stable; no PEEK issued; pushes still proceed.
- `iw_full`=1 with `in_valid`=1 -> `in_ready` stays 0; no addr 13 writes until `iw_full` drops.
- `TIMEOUT`=16, model never sets output ready -> abort 16 STAT cycles after last activity: write (0,0), `done` pulse, `error`=1; next `start` clears `error`.
- `num_blocks`=0 -> `done` one cycle after `start`, `cop_write_en` never asserted. `reset` during KEY -> all outputs at reset values next cycle.
